// File: rtl/byte_pair_loader.sv
// byte_pair_loader: serial-to-parallel loader that assembles an A/B operand pair and holds it until acknowledged
module byte_pair_loader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             pair_ack,
    output logic [WIDTH-1:0] B_out1,
    output logic [WIDTH-1:0] B_out2,
    output logic             pair_valid,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_t;

    state_t         state;
    logic [WIDTH-1:0] sh_a, sh_b, sh_a_nx, sh_b_nx;
    logic [CW-1:0]  cnt;
    logic           last;

    // shifted operand values including the bit arriving this cycle
    always_comb begin
        sh_a_nx = MSB_FIRST ? {sh_a[WIDTH-2:0], bit_in} : {bit_in, sh_a[WIDTH-1:1]};
        sh_b_nx = MSB_FIRST ? {sh_b[WIDTH-2:0], bit_in} : {bit_in, sh_b[WIDTH-1:1]};
        last    = cnt == CW'(WIDTH - 1);
    end

    // control FSM with registered outputs; the pair is published on the final B bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sh_a       <= '0;
            sh_b       <= '0;
            cnt        <= '0;
            B_out1     <= '0;
            B_out2     <= '0;
            pair_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= LOAD_A;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                LOAD_A: if (bit_valid) begin
                    sh_a  <= sh_a_nx;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    state <= last ? LOAD_B : LOAD_A;
                end
                LOAD_B: if (bit_valid) begin
                    sh_b <= sh_b_nx;
                    cnt  <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        state      <= HOLD;
                        B_out1     <= sh_a;
                        B_out2     <= sh_b_nx;
                        pair_valid <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                HOLD: if (pair_ack) begin
                    state      <= start ? LOAD_A : IDLE;
                    pair_valid <= 1'b0;
                    busy       <= start;
                    cnt        <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_pair_loader.sv
// tb_byte_pair_loader: checks MSB-first and LSB-first loaders against a bit-queue reference model
module tb_byte_pair_loader;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst, start, bit_in, bit_valid, pair_ack;
    logic [W-1:0] m1, m2, l1, l2;
    logic pv_m, busy_m, pv_l, busy_l;

    int checks = 0;
    int errors = 0;

    bit q[$];
    int mode = 0;
    logic [W-1:0] e1m = '0, e2m = '0, e1l = '0, e2l = '0;
    logic epv = 1'b0;

    always #5 clk = ~clk;

    byte_pair_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .pair_ack(pair_ack), .B_out1(m1), .B_out2(m2), .pair_valid(pv_m), .busy(busy_m));

    byte_pair_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .pair_ack(pair_ack), .B_out1(l1), .B_out2(l2), .pair_valid(pv_l), .busy(busy_l));

    function automatic bit rb();
        return bit'($urandom & 1);
    endfunction

    // operand value from W consecutive received bits, in arrival order
    function automatic logic [W-1:0] opval(int off, bit msb);
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i++)
            if (q[off+i]) v |= msb ? (W'(1) << (W - 1 - i)) : (W'(1) << i);
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 idle, 1 collecting bits, 2 holding a pair
    task automatic step(bit r, bit s, bit bv, bit b, bit ack);
        rst = r; start = s; bit_valid = bv; bit_in = b; pair_ack = ack;
        if (r) begin
            mode = 0; q.delete();
            e1m = '0; e2m = '0; e1l = '0; e2l = '0; epv = 1'b0;
        end else if (mode == 0) begin
            if (s) begin mode = 1; q.delete(); end
        end else if (mode == 1) begin
            if (bv) begin
                q.push_back(b);
                if (q.size() == 2 * W) begin
                    e1m = opval(0, 1'b1); e2m = opval(W, 1'b1);
                    e1l = opval(0, 1'b0); e2l = opval(W, 1'b0);
                    epv = 1'b1; mode = 2;
                end
            end
        end else if (ack) begin
            epv = 1'b0; mode = s ? 1 : 0; q.delete();
        end
        @(posedge clk); #1;
        chk("msb_out1", m1, e1m);
        chk("msb_out2", m2, e2m);
        chk("msb_pair_valid", pv_m, epv);
        chk("msb_busy", busy_m, mode == 1);
        chk("lsb_out1", l1, e1l);
        chk("lsb_out2", l2, e2l);
        chk("lsb_pair_valid", pv_l, epv);
        chk("lsb_busy", busy_l, mode == 1);
    endtask

    // send the low n bits of v, most significant first, with random gaps (exactly 3 before bit gap_at)
    task automatic send(logic [31:0] v, int n, int maxgap, int gap_at);
        for (int i = n - 1; i >= 0; i--) begin
            repeat ((i == gap_at) ? 3 : $urandom_range(maxgap, 0)) step(0, rb(), 0, rb(), rb());
            step(0, rb(), 1, v[i], rb());
        end
    endtask

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        chk("reset_out1", m1, 0);
        chk("reset_out2", m2, 0);
        chk("reset_valid", pv_m, 0);
        chk("reset_busy", busy_m, 0);

        repeat (3) step(0, 0, 1, 1, 1);
        chk("idle_ignore_busy", busy_m, 0);

        step(0, 1, 0, 0, 0);
        chk("start_busy", busy_m, 1);
        send(32'hA5, 8, 0, -1);
        send(32'h3C, 8, 0, -1);
        chk("s1_a", m1, 8'hA5);
        chk("s1_b", m2, 8'h3C);
        chk("s1_or", m1 | m2, 8'hBD);
        chk("s1_valid", pv_m, 1);
        chk("s1_busy", busy_m, 0);
        chk("s3_a", l1, 8'hA5);
        chk("s3_b", l2, 8'h3C);

        repeat (5) step(0, rb(), rb(), rb(), 0);
        chk("hold_a", m1, 8'hA5);
        chk("hold_b", m2, 8'h3C);
        step(0, 1, 0, 0, 1);
        chk("b2b_valid", pv_m, 0);
        chk("b2b_busy", busy_m, 1);
        send(32'hFF, 8, 2, -1);
        chk("old_a_kept", m1, 8'hA5);
        chk("old_b_kept", m2, 8'h3C);
        send(32'h00, 8, 2, -1);
        chk("s4_a", m1, 8'hFF);
        chk("s4_b", m2, 8'h00);

        step(0, 0, 0, 0, 1);
        chk("ack_idle_valid", pv_m, 0);
        chk("ack_keeps_a", m1, 8'hFF);
        step(0, 1, 0, 0, 0);
        send(32'hA5, 8, 3, 4);
        send(32'h3C, 8, 3, 4);
        chk("s2_a", m1, 8'hA5);
        chk("s2_b", m2, 8'h3C);
        chk("s2_valid", pv_m, 1);

        step(0, 1, 0, 0, 1);
        send(32'hA5, 8, 1, -1);
        send(32'h5, 3, 1, -1);
        step(1, 1, 1, 1, 1);
        chk("s5_out1", m1, 0);
        chk("s5_out2", m2, 0);
        chk("s5_valid", pv_m, 0);
        chk("s5_busy", busy_m, 0);
        step(0, 1, 0, 0, 0);
        send(32'h01, 8, 1, -1);
        send(32'h80, 8, 1, -1);
        chk("s5_msb_a", m1, 8'h01);
        chk("s5_msb_b", m2, 8'h80);
        chk("s5_lsb_a", l1, 8'h80);
        chk("s5_lsb_b", l2, 8'h01);

        repeat (20) begin
            step(0, 1, rb(), rb(), 1);
            send($urandom, 8, 2, -1);
            send($urandom, 8, 2, -1);
            repeat ($urandom_range(3, 0)) step(0, rb(), rb(), rb(), 0);
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
